// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for the shared bitwise logic slice.
// Accepts one op at a time, returns a registered result with id and zero flag.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             prio;
  logic             gnt_id;
  logic             accept;
  logic             idle_ok;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] res;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:  gnt_id = prio;
      req1_valid & ~req0_valid: gnt_id = 1'b1;
      default:                  gnt_id = 1'b0;
    endcase
  end

  // rst_n gates ready so nothing is offered while reset is held
  assign idle_ok = rst_n & (state == IDLE);
  assign accept  = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = idle_ok & req0_valid & ~gnt_id;
    req1_ready = idle_ok & req1_valid & gnt_id;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  always_comb begin
    res = '0;
    unique case (op_q)
      2'b00: res = a_q & b_q;
      2'b01: res = a_q | b_q;
      2'b10: res = a_q ^ b_q;
      2'b11: res = ~(a_q | b_q);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      prio     <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= gnt_id ? req1_op : req0_op;
        a_q  <= gnt_id ? req1_a  : req0_a;
        b_q  <= gnt_id ? req1_b  : req0_b;
        id_q <= gnt_id;
        prio <= ~gnt_id;
      end
      if (state == EXEC) begin
        rsp_data <= res;
        rsp_zero <= (res == '0);
      end
    end
  end

  assign rsp_id = id_q;

endmodule
